// File: rtl/modinv_scheduler.sv
// rtl/modinv_scheduler.sv - round-robin scheduler sharing one modular_inverse unit among NUM_REQ requesters
module modinv_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 256,
  parameter int LAUNCH_CYC = 2,
  parameter int TIMEOUT    = 4095
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_operand,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_error,
  output logic                       busy,
  output logic                       inv_reset,
  output logic [WIDTH-1:0]           inv_operand,
  input  logic [WIDTH-1:0]           inv_result,
  input  logic                       inv_done
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int LC_W = (LAUNCH_CYC > 1) ? $clog2(LAUNCH_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id_q;
  logic [WIDTH-1:0]   r_op_q;
  logic [NUM_REQ-1:0] r_ack;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_rsp_error;
  logic [LC_W-1:0]    r_launch_cnt;
  logic [WD_W-1:0]    r_wd_cnt;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_scan_idx;
  logic [WIDTH-1:0]   w_win_operand;
  logic               w_op_zero;
  logic               w_grant;
  logic               w_launch_last;
  logic               w_done_ok;
  logic               w_timeout;
  logic               w_handshake;

  // Round-robin scan: first asserted req starting just after the last winner.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scan_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    w_win_operand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_win_operand = req_operand[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_op_zero     = (w_win_operand == '0);
  assign w_grant       = (r_state == ST_IDLE) && w_found;
  assign w_launch_last = (r_launch_cnt == LC_W'(LAUNCH_CYC - 1));
  // The first RUN cycle sees the unit's stale Done from its previous run, so wd_cnt==0 masks it.
  assign w_done_ok     = (r_state == ST_RUN) && (r_wd_cnt != '0) && inv_done;
  assign w_timeout     = (r_state == ST_RUN) && (r_wd_cnt == WD_W'(TIMEOUT - 1));
  assign w_handshake   = rsp_valid && rsp_ready;

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; done has priority over timeout.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_next = w_op_zero ? ST_RESP : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (w_launch_last) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_done_ok || w_timeout) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_handshake) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Grant capture: operand, owner id, round-robin pointer and the one-cycle ack pulse.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
      r_id_q   <= '0;
      r_op_q   <= '0;
      r_ack    <= '0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_rr_ptr <= w_winner;
        r_id_q   <= w_winner;
        r_op_q   <= w_win_operand;
        r_ack    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
      end
    end
  end

  // Launch hold counter: keeps inv_reset high for LAUNCH_CYC cycles with the operand applied.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_launch_cnt <= '0;
    end else if (r_state == ST_LAUNCH && !w_launch_last) begin
      r_launch_cnt <= r_launch_cnt + LC_W'(1);
    end else begin
      r_launch_cnt <= '0;
    end
  end

  // Watchdog: counts RUN cycles from 0, cleared everywhere else.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // Response payload: cleared at grant (error if zero operand), loaded on done or abort.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else if (w_grant) begin
      r_rsp_data  <= '0;
      r_rsp_error <= w_op_zero;
    end else if (w_done_ok) begin
      r_rsp_data  <= inv_result;
      r_rsp_error <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b1;
    end
  end

  // A zero-operand job enters RESP while its ack is still pulsing; valid waits one cycle
  // so ack and response of one job never coincide.
  assign rsp_valid   = (r_state == ST_RESP) && (r_ack == '0);
  assign req_ack     = r_ack;
  assign rsp_id      = r_id_q;
  assign rsp_data    = r_rsp_data;
  assign rsp_error   = r_rsp_error;
  assign busy        = (r_state != ST_IDLE);
  assign inv_reset   = (r_state != ST_RUN);
  assign inv_operand = r_op_q;

endmodule

// File: tb/tb_modinv_scheduler.sv
// tb/tb_modinv_scheduler.sv - directed scoreboard bench for modinv_scheduler with a behavioural inverse unit
module tb_modinv_scheduler;

  localparam int NR  = 4;
  localparam int W   = 256;
  localparam int LC  = 2;
  localparam int TO  = 16;
  localparam int LAT = 4;
  localparam logic [511:0] P = {256'h0,
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F};

  logic            clk = 1'b0;
  logic            Reset;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_operand;
  logic [NR-1:0]   req_ack;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_error;
  logic            busy;
  logic            inv_reset;
  logic [W-1:0]    inv_operand;
  logic [W-1:0]    inv_result = '0;
  logic            inv_done = 1'b0;

  logic            never_done = 1'b0;
  int              stub_cnt = 0;
  int              n_tests = 0;
  int              n_fail = 0;
  logic [W-1:0]    inv2;
  logic [W-1:0]    inv3;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] data;
    logic         err;
    int           run;
    logic         chk3;
  } exp_t;

  exp_t sb[$];
  int   gq[$];

  modinv_scheduler #(.NUM_REQ(NR), .WIDTH(W), .LAUNCH_CYC(LC), .TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset), .req(req), .req_operand(req_operand), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .busy(busy), .inv_reset(inv_reset), .inv_operand(inv_operand),
    .inv_result(inv_result), .inv_done(inv_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] inv_p(input logic [W-1:0] a);
    logic [511:0] r, b;
    logic [W-1:0] e;
    r = 512'd1;
    b = {256'h0, a};
    e = W'(P - 512'd2);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * b) % P;
      b = (b * b) % P;
    end
    return W'(r);
  endfunction

  // Behavioural unit: parks while inv_reset, Done sticky until the next run starts.
  always @(posedge clk) begin
    if (inv_reset) begin
      stub_cnt <= 0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == 0) inv_done <= 1'b0;
      if (!never_done && stub_cnt == LAT - 1) begin
        inv_done   <= 1'b1;
        inv_result <= inv_p(inv_operand);
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] v);
    req_operand[i*W +: W] = v;
  endtask

  task automatic expect_job(input int id, input logic [W-1:0] d, input logic e, input int run, input logic c3);
    exp_t x;
    x.id = 2'(id); x.data = d; x.err = e; x.run = run; x.chk3 = c3;
    sb.push_back(x);
    gq.push_back(id);
  endtask

  task automatic collect(input int n, input int budget, input logic drop_on_ack);
    int got = 0;
    int cyc = 0;
    int run = 0;
    logic [NR-1:0] oh;
    exp_t x;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (req_ack != '0) begin
        check("grant_queue_nonempty", 512'(gq.size() > 0), 512'd1);
        if (gq.size() > 0) begin
          oh = 4'b0001 << gq.pop_front();
          check("req_ack", req_ack, oh);
        end
        check("ack_without_rsp", rsp_valid, 1'b0);
        if (drop_on_ack) req = req & ~req_ack;
      end
      if (!inv_reset) run++;
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", 512'(sb.size() > 0), 512'd1);
        if (sb.size() > 0) begin
          x = sb.pop_front();
          check("rsp_id", rsp_id, x.id);
          check("rsp_data", rsp_data, x.data);
          check("rsp_error", rsp_error, x.err);
          check("run_cycles", 512'(run), 512'(x.run));
          check("reset_high_in_resp", inv_reset, 1'b1);
          if (x.chk3) check("data_times_3", ({256'h0, rsp_data} * 512'd3) % P, 512'd1);
        end
        run = 0;
        got++;
        if (got == n) req = '0;
      end
    end
    check("collect_complete", 512'(got), 512'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, req_ack, 4'b0);
    check({tag, "_valid"}, rsp_valid, 1'b0);
    check({tag, "_id"}, rsp_id, 2'd0);
    check({tag, "_data"}, rsp_data, '0);
    check({tag, "_error"}, rsp_error, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_inv_reset"}, inv_reset, 1'b1);
    check({tag, "_inv_operand"}, inv_operand, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic saw;
    inv2 = W'((P + 512'd1) >> 1);
    inv3 = W'((512'd2 * P + 512'd1) / 512'd3);
    Reset = 1'b1; req = '0; req_operand = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    Reset = 1'b0;
    @(negedge clk);

    // Fairness: all four request operand 3; first grant after reset is 0.
    for (int i = 0; i < NR; i++) set_op(i, 256'd3);
    req = 4'b1111;
    expect_job(0, inv3, 1'b0, LAT + 1, 1'b1);
    expect_job(1, inv3, 1'b0, LAT + 1, 1'b1);
    expect_job(2, inv3, 1'b0, LAT + 1, 1'b1);
    expect_job(3, inv3, 1'b0, LAT + 1, 1'b1);
    expect_job(0, inv3, 1'b0, LAT + 1, 1'b1);
    collect(5, 300, 1'b0);

    // Inverse of 1.
    set_op(0, 256'd1);
    req = 4'b0001;
    expect_job(0, 256'd1, 1'b0, LAT + 1, 1'b0);
    collect(1, 60, 1'b1);

    // Inverse of 2; stale Done from the previous run must be ignored.
    set_op(1, 256'd2);
    req = 4'b0010;
    expect_job(1, inv2, 1'b0, LAT + 1, 1'b0);
    collect(1, 60, 1'b1);

    // Zero operand: no RUN at all, error response.
    set_op(2, 256'd0);
    req = 4'b0100;
    expect_job(2, 256'd0, 1'b1, 0, 1'b0);
    collect(1, 60, 1'b1);

    // Unit never finishes: abort after exactly TO RUN cycles, then a normal job.
    never_done = 1'b1;
    set_op(3, 256'd5);
    req = 4'b1000;
    expect_job(3, 256'd0, 1'b1, TO, 1'b0);
    collect(1, 100, 1'b1);
    never_done = 1'b0;
    set_op(0, 256'd1);
    req = 4'b0001;
    expect_job(0, 256'd1, 1'b0, LAT + 1, 1'b0);
    collect(1, 60, 1'b1);

    // Reset mid-RUN drops the job.
    set_op(1, 256'd2);
    req = 4'b0010;
    k = 0;
    while (req_ack == '0 && k < 20) begin @(negedge clk); k++; end
    check("t6_ack", req_ack, 4'b0010);
    req = '0;
    k = 0;
    while (inv_reset && k < 20) begin @(negedge clk); k++; end
    check("t6_in_run", inv_reset, 1'b0);
    @(negedge clk);
    Reset = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    Reset = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    check("t6_no_dropped_rsp", saw, 1'b0);
    check("t6_idle_after_reset", busy, 1'b0);

    // Next job held under backpressure.
    rsp_ready = 1'b0;
    set_op(2, 256'd3);
    req = 4'b0100;
    k = 0;
    while (req_ack == '0 && k < 20) begin @(negedge clk); k++; end
    check("t6_next_ack", req_ack, 4'b0100);
    req = '0;
    k = 0;
    while (!rsp_valid && k < 60) begin @(negedge clk); k++; end
    check("t6_rsp_valid", rsp_valid, 1'b1);
    check("t6_rsp_id", rsp_id, 2'd2);
    check("t6_rsp_error", rsp_error, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("t6_hold_valid", rsp_valid, 1'b1);
      check("t6_hold_data", rsp_data, inv3);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_released", rsp_valid, 1'b0);
    check("t6_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
